// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS run-control sequencer: host command codes,
// sequencer state encoding and dump framing.
package mips_debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  // Bytes per dump: four PC bytes then four cycle-count bytes.
  localparam int unsigned DUMP_LEN = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

endpackage

// File: rtl/dump_serializer.sv
// Serialises a {count, pc} snapshot to the UART transmitter, LSB first,
// PC bytes before count bytes, one byte per accepted handshake.
module dump_serializer
  import mips_debug_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*LEN-1:0] snapshot,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             done
);

  logic [LEN-1:0]   pc_q;
  logic [LEN-1:0]   cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept_c;

  // Bytes 0..3 come from the PC, bytes 4..7 from the cycle count.
  function automatic logic [7:0] pick_byte(input logic [LEN-1:0]   pc,
                                           input logic [LEN-1:0]   cnt,
                                           input logic [IDX_W-1:0] idx);
    logic [4:0] sh;
    sh = {idx[1:0], 3'b000};
    return idx[2] ? 8'(cnt >> sh) : 8'(pc >> sh);
  endfunction

  // Handshake and last-byte detection.
  always_comb begin
    accept_c = tx_valid && tx_ready;
    done     = accept_c && (idx_q == IDX_W'(DUMP_LEN - 1));
  end

  // Snapshot load, byte index and registered tx outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (start) begin
      pc_q     <= snapshot[LEN-1:0];
      cnt_q    <= snapshot[2*LEN-1:LEN];
      idx_q    <= '0;
      tx_data  <= pick_byte(snapshot[LEN-1:0], snapshot[2*LEN-1:LEN], '0);
      tx_valid <= 1'b1;
    end else if (accept_c) begin
      if (done) begin
        idx_q    <= '0;
        tx_valid <= 1'b0;
      end else begin
        idx_q   <= idx_q + IDX_W'(1);
        tx_data <= pick_byte(pc_q, cnt_q, idx_q + IDX_W'(1));
      end
    end
  end

endmodule

// File: rtl/debug_sequencer.sv
// Run-control sequencer: decodes host command bytes into run, step, halt and
// clear, owns the pipeline enable and cycle counter, and dumps PC and count
// after every stop.
module debug_sequencer
  import mips_debug_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic [LEN-1:0] in_pc,
  input  logic           in_halt,
  output logic           out_pipe_enable,
  output logic           out_pipe_clear,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           out_busy
);

  state_e         state_q;
  logic [LEN-1:0] cycle_cnt_q;
  logic [LEN-1:0] cnt_snap_c;
  logic           cmd_run_c;
  logic           cmd_step_c;
  logic           cmd_halt_c;
  logic           cmd_clear_c;
  logic           clear_c;
  logic           dump_start_c;
  logic           dump_done;

  // Command decode and dump-entry detection.
  always_comb begin
    cmd_run_c    = rx_valid && (rx_data == CMD_RUN);
    cmd_step_c   = rx_valid && (rx_data == CMD_STEP);
    cmd_halt_c   = rx_valid && (rx_data == CMD_HALT);
    cmd_clear_c  = rx_valid && (rx_data == CMD_CLEAR);
    clear_c      = (state_q == ST_IDLE) && cmd_clear_c;
    dump_start_c = 1'b0;
    case (state_q)
      ST_IDLE: dump_start_c = cmd_run_c && in_halt;
      ST_RUN:  dump_start_c = in_halt || cmd_halt_c;
      ST_STEP: dump_start_c = 1'b1;
      default: dump_start_c = 1'b0;
    endcase
    // Snapshot includes the cycle being counted at the entry edge.
    cnt_snap_c = cycle_cnt_q + LEN'(out_pipe_enable);
  end

  // Run-control FSM with registered enable, clear and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      out_pipe_enable <= 1'b0;
      out_pipe_clear  <= 1'b0;
      out_busy        <= 1'b0;
    end else begin
      out_pipe_clear <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_run_c) begin
            out_busy <= 1'b1;
            if (in_halt) begin
              state_q <= ST_DUMP;
            end else begin
              state_q         <= ST_RUN;
              out_pipe_enable <= 1'b1;
            end
          end else if (cmd_step_c) begin
            state_q         <= ST_STEP;
            out_pipe_enable <= 1'b1;
            out_busy        <= 1'b1;
          end else if (cmd_clear_c) begin
            out_pipe_clear <= 1'b1;
          end
        end
        ST_RUN: begin
          if (dump_start_c) begin
            state_q         <= ST_DUMP;
            out_pipe_enable <= 1'b0;
          end
        end
        ST_STEP: begin
          state_q         <= ST_DUMP;
          out_pipe_enable <= 1'b0;
        end
        ST_DUMP: begin
          if (dump_done) begin
            state_q  <= ST_IDLE;
            out_busy <= 1'b0;
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          out_pipe_enable <= 1'b0;
          out_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Executed-cycle counter; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
    end else if (clear_c) begin
      cycle_cnt_q <= '0;
    end else if (out_pipe_enable) begin
      cycle_cnt_q <= cycle_cnt_q + LEN'(1);
    end
  end

  dump_serializer #(
    .LEN(LEN)
  ) u_dump (
    .clk      (clk),
    .reset    (reset),
    .start    (dump_start_c),
    .snapshot ({cnt_snap_c, in_pc}),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (dump_done)
  );

endmodule

// File: tb/tb_debug_sequencer.sv
// Randomised scoreboard bench for debug_sequencer.
module tb_debug_sequencer;
  import mips_debug_pkg::*;

  localparam int unsigned LEN = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [LEN-1:0] in_pc;
  logic           in_halt;
  logic           out_pipe_enable;
  logic           out_pipe_clear;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           out_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned bytes_seen   = 0;
  int unsigned bytes_pushed = 0;
  int unsigned ready_mode   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] m_cnt;
  logic        mon_stalled = 1'b0;
  logic [7:0]  mon_held    = 8'h00;

  always #5 clk = ~clk;

  debug_sequencer #(.LEN(LEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .in_pc           (in_pc),
    .in_halt         (in_halt),
    .out_pipe_enable (out_pipe_enable),
    .out_pipe_clear  (out_pipe_clear),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .out_busy        (out_busy)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference dump: PC bytes LSB first, then count bytes LSB first.
  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cnt);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(pc >> (8 * k)));
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(cnt >> (8 * k)));
    bytes_pushed += 8;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((out_busy || exp_q.size() != 0) && k < 400) begin
      cycle();
      k++;
    end
    check({name, "_idle_timeout"}, 64'(k < 400), 64'd1);
    check({name, "_idle_tx_valid"}, 64'(tx_valid), 64'd0);
  endtask

  task automatic do_step(input logic [31:0] pc);
    in_pc = pc;
    send_cmd(CMD_STEP);
    check("step_enable", 64'(out_pipe_enable), 64'd1);
    check("step_busy", 64'(out_busy), 64'd1);
    push_dump(pc, m_cnt + 32'd1);
    m_cnt = m_cnt + 32'd1;
    cycle();
    check("step_enable_off", 64'(out_pipe_enable), 64'd0);
    check("step_tx_valid", 64'(tx_valid), 64'd1);
    in_pc = $urandom;
    wait_idle("step");
  endtask

  task automatic do_run(input int unsigned n, input bit use_h, input bit junk, input logic [31:0] pc);
    logic [7:0] b;
    in_pc   = pc;
    in_halt = 1'b0;
    send_cmd(CMD_RUN);
    for (int unsigned k = 1; k < n; k++) begin
      check("run_enable", 64'(out_pipe_enable), 64'd1);
      if (junk) begin
        b = 8'($urandom);
        if (b == CMD_HALT) b = 8'h00;
        rx_data  = b;
        rx_valid = 1'b1;
      end
      cycle();
      rx_valid = 1'b0;
    end
    check("run_enable", 64'(out_pipe_enable), 64'd1);
    if (use_h) begin
      rx_data  = CMD_HALT;
      rx_valid = 1'b1;
    end else begin
      in_halt = 1'b1;
    end
    push_dump(pc, m_cnt + n);
    m_cnt = m_cnt + n;
    cycle();
    rx_valid = 1'b0;
    in_halt  = 1'b0;
    check("halt_enable_off", 64'(out_pipe_enable), 64'd0);
    check("halt_tx_valid", 64'(tx_valid), 64'd1);
    in_pc = $urandom;
    if (junk) begin
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: rx_data = CMD_STEP;
          1: rx_data = 8'h7F;
          2: rx_data = CMD_RUN;
          default: rx_data = CMD_CLEAR;
        endcase
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        check("dump_busy_junk", 64'(out_busy), 64'd1);
        check("dump_enable_junk", 64'(out_pipe_enable), 64'd0);
      end
    end
    wait_idle("run");
  endtask

  task automatic do_clear();
    send_cmd(CMD_CLEAR);
    check("clear_pulse", 64'(out_pipe_clear), 64'd1);
    check("clear_busy", 64'(out_busy), 64'd0);
    m_cnt = 32'd0;
    cycle();
    check("clear_pulse_off", 64'(out_pipe_clear), 64'd0);
  endtask

  task automatic do_ignored(input logic [7:0] b);
    send_cmd(b);
    check("ignored_busy", 64'(out_busy), 64'd0);
    check("ignored_enable", 64'(out_pipe_enable), 64'd0);
    check("ignored_tx_valid", 64'(tx_valid), 64'd0);
    check("ignored_clear", 64'(out_pipe_clear), 64'd0);
  endtask

  task automatic do_run_halted(input logic [31:0] pc);
    in_pc   = pc;
    in_halt = 1'b1;
    push_dump(pc, m_cnt);
    send_cmd(CMD_RUN);
    check("rh_enable", 64'(out_pipe_enable), 64'd0);
    check("rh_tx_valid", 64'(tx_valid), 64'd1);
    in_halt = 1'b0;
    in_pc   = $urandom;
    cycle();
    check("rh_enable_next", 64'(out_pipe_enable), 64'd0);
    wait_idle("run_halted");
  endtask

  task automatic do_reset_mid_dump(input logic [31:0] pc);
    ready_mode = 0;
    in_pc = pc;
    push_dump(pc, m_cnt + 32'd1);
    send_cmd(CMD_STEP);
    repeat (4) cycle();
    check("pre_reset_byte3", 64'(tx_data), 64'(8'(pc >> 24)));
    reset = 1'b0;
    bytes_pushed -= exp_q.size();
    exp_q.delete();
    m_cnt = 32'd0;
    #1;
    check("mid_reset_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_reset_busy", 64'(out_busy), 64'd0);
    check("mid_reset_enable", 64'(out_pipe_enable), 64'd0);
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  // tx_ready driver: held high, random, or alternating.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares each accepted byte and holds stalled bytes steady.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_stalled = 1'b0;
      end else begin
        if (mon_stalled) begin
          check("stall_valid", 64'(tx_valid), 64'd1);
          check("stall_data", 64'(tx_data), 64'(mon_held));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
          end else begin
            check("dump_byte", 64'(tx_data), 64'(exp_q.pop_front()));
          end
          bytes_seen++;
        end
        mon_stalled = tx_valid && !tx_ready;
        mon_held    = tx_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned op;
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    in_pc    = '0;
    in_halt  = 1'b0;
    m_cnt    = 32'd0;
    repeat (3) cycle();
    check("rst_enable", 64'(out_pipe_enable), 64'd0);
    check("rst_clear", 64'(out_pipe_clear), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(out_busy), 64'd0);
    reset = 1'b1;
    cycle();

    do_step(32'h0000_0004);
    do_run(10, 1'b0, 1'b0, 32'h0040_0100);
    ready_mode = 2;
    do_step(32'hDEAD_BEEF);
    ready_mode = 0;
    do_clear();
    do_step(32'h0000_1000);
    do_run(5, 1'b1, 1'b1, 32'h1234_5678);
    do_reset_mid_dump(32'hA1B2_C3D4);
    do_step(32'h0000_0008);
    do_ignored(CMD_HALT);
    do_ignored(8'h7F);
    do_run_halted(32'hCAFE_0000);

    for (int i = 0; i < 30; i++) begin
      ready_mode = $urandom_range(0, 2);
      op = $urandom_range(0, 5);
      case (op)
        0: do_step($urandom);
        1: do_run($urandom_range(1, 20), 1'b0, ready_mode == 0, $urandom);
        2: do_run($urandom_range(1, 20), 1'b1, ready_mode == 0, $urandom);
        3: do_clear();
        4: do_ignored(8'h30 + 8'($urandom_range(0, 15)));
        default: do_run_halted($urandom);
      endcase
    end
    ready_mode = 0;
    repeat (4) cycle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("byte_count", 64'(bytes_seen), 64'(bytes_pushed));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

Run-control sequencer for the MIPS pipeline. It sits between the UART byte interface and the `top` pipeline and owns the pipeline-wide enable. It decodes single-byte host commands into continuous run, single step, halt and soft clear. After every stop it serialises the current PC and the executed-cycle count back to the host as 8 bytes.

## Interface
Parameters:
- `LEN`, default 32: width of the PC and the cycle counter.

Ports:
- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Low forces every register to its reset value immediately.
- `rx_data`, input, 8: received command byte.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `in_pc`, input, LEN: current fetch PC from `instruction_fetch`.
- `in_halt`, input, 1: a halt instruction has reached writeback. Level signal.
- `out_pipe_enable`, output, 1: registered clock-enable for all pipeline stages. Reset value 0.
- `out_pipe_clear`, output, 1: one-cycle synchronous clear pulse to the pipeline. Reset value 0.
- `tx_data`, output, 8: dump byte. Reset value 0x00.
- `tx_valid`, output, 1: `tx_data` is valid. Reset value 0.
- `tx_ready`, input, 1: the UART transmitter accepts the byte when `tx_valid && tx_ready`.
- `out_busy`, output, 1: high in any state other than IDLE. Reset value 0.

## Operation
- States: IDLE, RUN, STEP, DUMP. Reset state is IDLE.
- Command codes:
  - 0x52 'R': run.
  - 0x53 'S': step.
  - 0x48 'H': halt.
  - 0x43 'C': clear.
  - Every other code is ignored with no state change.
- IDLE:
  - 'R' with `in_halt` low goes to RUN.
  - 'R' with `in_halt` high goes straight to DUMP; enable is never raised.
  - 'S' goes to STEP.
  - 'C' pulses `out_pipe_clear` for one cycle, zeroes the cycle counter and stays in IDLE.
  - 'H' is ignored.
- RUN:
  - `out_pipe_enable` = 1.
  - `in_halt` high, or an 'H' strobe, goes to DUMP.
  - All other bytes are dropped.
- STEP:
  - `out_pipe_enable` = 1 for exactly one cycle, then DUMP, unconditionally.
  - `in_halt` does not matter here.
- DUMP:
  - On entry, snapshot `in_pc` and the cycle counter.
  - Send 8 bytes: PC bytes 0..3 (LSB first), then counter bytes 0..3 (LSB first).
  - The byte index advances only on `tx_valid && tx_ready`.
  - After byte 7 is accepted, return to IDLE.
  - All `rx_valid` strobes are dropped.
- Cycle counter: LEN bits. Increments on every edge where `out_pipe_enable` = 1. Wraps modulo 2^LEN with no flag.
- Reset asserted mid-operation (any state, including part-way through a dump) returns to IDLE with all outputs at reset values. Any partial dump is abandoned.

## Timing
- A command strobed in cycle t takes effect at the edge ending cycle t. The new state and outputs are visible in cycle t+1.
- Step: enable is high in cycle t+1 only. DUMP starts in t+2 with `tx_valid` = 1 and byte 0 on `tx_data`. The snapshot taken at the start of t+2 includes the stepped cycle.
- Halt in RUN: `in_halt` or 'H' sampled high in cycle t means enable is low from t+1. Cycle t is still counted. `tx_valid` rises in t+1.
- `tx_valid` stays high with stable `tx_data` until accepted. With `tx_ready` held at 1 the dump lasts exactly 8 cycles.
- Clear: `out_pipe_clear` is high in cycle t+1 only, and the counter reads 0 from t+1.
- Between accepting byte 7 and the next dump, `tx_valid` is low for at least one cycle (the IDLE cycle).

## Structure
- Shared package `mips_debug_pkg` holds:
  - the command codes (CMD_RUN, CMD_STEP, CMD_HALT, CMD_CLEAR);
  - the state encoding;
  - the dump length constant (8).
- One sub-module, `dump_serializer`:
  - loads a 2×LEN snapshot on `start`;
  - drives the `tx_*` handshake and its 3-bit byte index;
  - raises `done` when the last byte is accepted.
- The FSM and the cycle counter stay in `debug_sequencer`.

## Test plan
- Reset then 'S' with `in_pc` = 0x00000004 -> enable high for one cycle; bytes 04 00 00 00 01 00 00 00 sent; back to IDLE.
- 'R', then `in_halt` raised after 10 enabled cycles -> enable low the next cycle; counter bytes read 0x0A (plus any prior count); 8 bytes sent.
- Dump with `tx_ready` toggling 1/0 -> `tx_data` stays stable while stalled; exactly 8 handshakes; no byte duplicated or skipped.
- 'C' in IDLE, then 'S' -> one-cycle `out_pipe_clear` pulse; following dump reports count 1.
- 'R' then 'H' at cycle 5; 'S' and 0x7F strobed during DUMP -> both ignored; stop within 1 cycle of 'H'.
- `reset` pulsed low during dump byte 3 -> `tx_valid` = 0, state IDLE, counter 0 immediately; next 'S' dumps cleanly.
